muldiv_unit: RTL

- Iterative signed multiply/divide responder serving the EXE stage's HI/LO requests.
- EXE initiates an operation with a start pulse, stalls on busy, and consumes the result on done.
- Owns the architectural HI and LO registers; mfhi and mflo read them directly.
- Replaces the single-cycle mult/div path so the pipeline clock is not bounded by a 32-bit divider.

---
 rtl/muldiv_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed multiply/divide engine that owns the HI/LO
// registers of the EXE stage.
// - A start pulse in IDLE latches the operand magnitudes and signs.
// - RUN performs one shift-add or restoring-divide step per clock.
// - FIX applies the sign correction, writes hi/lo and pulses done.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   start    request strobe, sampled only in IDLE
//   op       0 = signed mult, 1 = signed div
//   a, b     rs / rt operands (multiplicand/dividend, multiplier/divisor)
//   busy     operation in progress (RUN or FIX)
//   done     one-cycle pulse; hi/lo are updated and valid
//   div_zero pulses with done when a div had b == 0 (hi/lo left unchanged)
//   hi, lo   architectural HI / LO registers
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_op;
    logic                 r_sign_a;
    logic                 r_sign_b;
    logic                 r_divz;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_mag_b;
    // r_upper/r_lower form one 2*WIDTH shift register:
    //   mult: partial product high half / multiplier shifting out, product shifting in
    //   div : partial remainder / dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]     r_upper;
    logic [WIDTH-1:0]     r_lower;

    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_div_shift;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_sub;
    logic [WIDTH-1:0]     w_upper_nxt;
    logic [WIDTH-1:0]     w_lower_nxt;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // The magnitude of the most negative value is 2^(WIDTH-1), which is still exact as an unsigned number.
    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? neg_w(x) : x;
    endfunction

    // One iteration step for the selected operation.
    always_comb begin
        w_mul_sum   = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_mag_b} : {(WIDTH+1){1'b0}});
        w_div_shift = {r_upper, r_lower[WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_mag_b});
        // When w_div_ge is set, the true difference is below the divisor, so the low WIDTH bits are exact.
        w_div_sub   = w_div_shift[WIDTH-1:0] - r_mag_b;
        if (r_op) begin
            w_upper_nxt = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
            w_lower_nxt = {r_lower[WIDTH-2:0], w_div_ge};
        end else begin
            w_upper_nxt = w_mul_sum[WIDTH:1];
            w_lower_nxt = {w_mul_sum[0], r_lower[WIDTH-1:1]};
        end
    end

    // Sign correction applied in FIX.
    always_comb begin
        w_prod = {r_upper, r_lower};
        if (r_sign_a ^ r_sign_b) begin
            w_prod = neg_2w({r_upper, r_lower});
            w_quo  = neg_w(r_lower);
        end else begin
            w_quo  = r_lower;
        end
        if (r_sign_a) begin
            w_rem = neg_w(r_upper);
        end else begin
            w_rem = r_upper;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (op && (b == {WIDTH{1'b0}})) ? S_FIX : S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == CNT_W'(WIDTH-1)) begin
                    w_state_nxt = S_FIX;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            busy     <= (w_state_nxt != S_IDLE);
            done     <= (r_state == S_FIX);
            div_zero <= (r_state == S_FIX) && r_divz;
        end
    end

    // Datapath: operand capture, iteration and the HI/LO write-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op     <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_divz   <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
            r_mag_b  <= {WIDTH{1'b0}};
            r_upper  <= {WIDTH{1'b0}};
            r_lower  <= {WIDTH{1'b0}};
            hi       <= {WIDTH{1'b0}};
            lo       <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_sign_a <= a[WIDTH-1];
                        r_sign_b <= b[WIDTH-1];
                        r_divz   <= op && (b == {WIDTH{1'b0}});
                        r_cnt    <= {CNT_W{1'b0}};
                        r_mag_b  <= abs_w(b);
                        r_upper  <= {WIDTH{1'b0}};
                        r_lower  <= abs_w(a);
                    end
                end
                S_RUN: begin
                    r_upper <= w_upper_nxt;
                    r_lower <= w_lower_nxt;
                    r_cnt   <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                S_FIX: begin
                    // A divide by zero leaves HI/LO untouched.
                    if (!r_divz) begin
                        if (r_op) begin
                            hi <= w_rem;
                            lo <= w_quo;
                        end else begin
                            hi <= w_prod[2*WIDTH-1:WIDTH];
                            lo <= w_prod[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
